// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the 5-stage LEGv8 pipeline, directly upstream of
// the IF/ID register. Owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory, buffers returned instructions (with
// their PCs) in an in-order ring buffer and presents them to IF/ID through a
// valid/ready handshake. A taken branch (redirect) squashes everything that is
// buffered or still in flight.
//
// Ports
//   clk, reset       clock; synchronous active-low reset
//   imem_req_*       fetch request channel (valid/ready, addr = fetch PC)
//   imem_rsp_*       in-order fetch responses (valid, data)
//   redirect_*       taken branch from MEM: flush and restart at redirect_pc
//   if_valid/ready   handshake toward IF/ID carrying {if_pc, if_instr}
//   err_spurious     sticky flag: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               err_spurious
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    entry_pc    [DEPTH];
    logic [INSTR_W-1:0] entry_instr [DEPTH];
    logic [DEPTH-1:0]   entry_filled;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   fill_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   pend_cnt;
    logic [CNT_W-1:0]   drop_cnt;

    logic               issue_fire;
    logic               pop_fire;
    logic               rsp_fill;
    logic               rsp_spurious;
    logic [CNT_W-1:0]   drop_sum;
    logic [CNT_W-1:0]   drop_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Handshakes. Outputs are forced low while reset is held because the
    // state registers only clear at the next edge.
    assign imem_req_valid = reset && !redirect_valid && (count < CNT_W'(DEPTH))
                            && (drop_cnt == '0);
    assign imem_req_addr  = fetch_pc;
    assign issue_fire     = imem_req_valid && imem_req_ready;

    assign if_valid = reset && (count != '0) && entry_filled[head] && !redirect_valid;
    assign if_pc    = reset ? entry_pc[head]    : '0;
    assign if_instr = reset ? entry_instr[head] : '0;
    assign pop_fire = if_valid && if_ready;

    // pend_cnt counts allocated-but-unfilled entries, i.e. requests in flight
    // that still own a slot. A response with neither a pending drop nor an
    // unfilled slot to land in is spurious, with or without a redirect.
    assign rsp_fill     = imem_rsp_valid && !redirect_valid && (drop_cnt == '0)
                          && (pend_cnt != '0);
    assign rsp_spurious = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt == '0);

    // On redirect every unfilled slot turns into a response to be dropped; a
    // response arriving in that same cycle retires one of them immediately.
    // drop_cnt is only nonzero when no entries are allocated, so the sum
    // never exceeds DEPTH.
    always_comb begin
        drop_sum  = drop_cnt + pend_cnt;
        drop_next = drop_sum;
        if (imem_rsp_valid && (drop_sum != '0))
            drop_next = drop_sum - CNT_W'(1);
    end

    // Ring buffer, pointers and counters. Popped entries keep a stale filled
    // bit; it is harmless because count gates if_valid and the bit is cleared
    // when the slot is reallocated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc     <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            count        <= '0;
            pend_cnt     <= '0;
            drop_cnt     <= '0;
            entry_filled <= '0;
            err_spurious <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc[i]    <= '0;
                entry_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc     <= redirect_pc;
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            count        <= '0;
            pend_cnt     <= '0;
            entry_filled <= '0;
            drop_cnt     <= drop_next;
            if (rsp_spurious)
                err_spurious <= 1'b1;
        end else begin
            if (issue_fire) begin
                entry_pc[tail]     <= fetch_pc;
                entry_filled[tail] <= 1'b0;
                tail               <= ptr_inc(tail);
                fetch_pc           <= fetch_pc + PC_W'(4);
            end
            if (rsp_fill) begin
                entry_instr[fill_ptr]  <= imem_rsp_data;
                entry_filled[fill_ptr] <= 1'b1;
                fill_ptr               <= ptr_inc(fill_ptr);
            end
            if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CNT_W'(1);
            if (rsp_spurious)
                err_spurious <= 1'b1;
            if (pop_fire)
                head <= ptr_inc(head);
            count    <= count + CNT_W'(issue_fire) - CNT_W'(pop_fire);
            pend_cnt <= pend_cnt + CNT_W'(issue_fire) - CNT_W'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. An in-order instruction memory with
// random accept and random latency drives the DUT; a queue-based reference of
// the fetch stage predicts every output each cycle. Directed scenarios cover
// reset start-up, stalls, redirect squashing, same-cycle redirect/response,
// spurious responses and PC wrap; a random phase follows.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               imem_req_valid;
    logic               imem_req_ready = 1'b0;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data = '0;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               if_valid;
    logic               if_ready = 1'b0;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               err_spurious;

    if_fetch_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .err_spurious  (err_spurious)
    );

    always #5 clk = ~clk;

    // Reference: buffered fetches in program order, plus outstanding drops.
    typedef struct {
        logic [63:0] pc;
        bit          filled;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;

    entry_t      mq[$];
    mrsp_t       memq[$];
    logic [63:0] acc[$];
    logic [63:0] m_fetch_pc;
    int          m_drop;
    bit          m_err;

    int cyc;
    int ready_pct;
    int rsp_pct;
    int mem_lat_max;
    bit force_rsp;

    int checks   = 0;
    int failures = 0;

    logic        last_req;
    logic [63:0] last_addr;
    logic        last_ifv;
    logic [63:0] last_pc;
    logic        last_err;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelOutputs(output bit e_req, output bit e_ifv,
                                output logic [63:0] e_pc, output logic [31:0] e_instr);
        e_req   = 1'b0;
        e_ifv   = 1'b0;
        e_pc    = '0;
        e_instr = '0;
        if (reset) begin
            e_req = !redirect_valid && (mq.size() < DEPTH) && (m_drop == 0);
            e_ifv = (mq.size() > 0) && mq[0].filled && !redirect_valid;
            if (e_ifv) begin
                e_pc    = mq[0].pc;
                e_instr = mq[0].data;
            end
        end
    endtask

    task automatic modelUpdate(input bit e_req, input bit e_ifv);
        int unf;
        int k;
        if (!reset) begin
            mq.delete();
            memq.delete();
            m_fetch_pc = RESET_PC;
            m_drop     = 0;
            m_err      = 1'b0;
            return;
        end
        if (imem_rsp_valid && !force_rsp)
            void'(memq.pop_front());
        unf = 0;
        foreach (mq[i])
            if (!mq[i].filled)
                unf++;
        if (redirect_valid) begin
            if (imem_rsp_valid) begin
                if (m_drop + unf == 0)
                    m_err = 1'b1;
                else
                    m_drop = m_drop + unf - 1;
            end else begin
                m_drop = m_drop + unf;
            end
            mq.delete();
            m_fetch_pc = redirect_pc;
        end else begin
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    k = -1;
                    foreach (mq[i])
                        if (!mq[i].filled && k < 0)
                            k = i;
                    if (k < 0) begin
                        m_err = 1'b1;
                    end else begin
                        mq[k].filled = 1'b1;
                        mq[k].data   = imem_rsp_data;
                    end
                end
            end
            if (e_ifv && if_ready)
                void'(mq.pop_front());
            if (e_req && imem_req_ready) begin
                mq.push_back('{pc: m_fetch_pc, filled: 1'b0, data: '0});
                memq.push_back('{data: instr_of(m_fetch_pc),
                                 due: cyc + int'($urandom_range(mem_lat_max))});
                m_fetch_pc = m_fetch_pc + 64'd4;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare against the reference away from
    // the active edge, then advance the reference on the edge.
    task automatic applyStimulus(input bit redir, input logic [63:0] rpc, input bit rdy);
        bit          e_req;
        bit          e_ifv;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (force_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else if (reset && memq.size() > 0 && memq[0].due <= cyc
                     && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        modelOutputs(e_req, e_ifv, e_pc, e_instr);
        checkOutput("req_valid", 64'(imem_req_valid), 64'(e_req));
        if (e_req)
            checkOutput("req_addr", imem_req_addr, m_fetch_pc);
        checkOutput("if_valid", 64'(if_valid), 64'(e_ifv));
        if (e_ifv || !reset) begin
            checkOutput("if_pc", if_pc, e_pc);
            checkOutput("if_instr", 64'(if_instr), 64'(e_instr));
        end
        checkOutput("err_spurious", 64'(err_spurious), 64'(m_err));
        last_req  = imem_req_valid;
        last_addr = imem_req_addr;
        last_ifv  = if_valid;
        last_pc   = if_pc;
        last_err  = err_spurious;
        if (reset && if_valid && if_ready)
            acc.push_back(if_pc);
        @(posedge clk);
        cyc++;
        modelUpdate(e_req, e_ifv);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        reset = 1'b1;
    endtask

    task automatic checkAccSequence(input string tag, input logic [63:0] start, input int min_len);
        checkOutput({tag, "_len"}, 64'(acc.size() >= min_len), 64'd1);
        foreach (acc[i])
            checkOutput(tag, acc[i], start + 64'(4 * i));
    endtask

    initial begin
        logic [63:0] rpc;
        ready_pct   = 100;
        rsp_pct     = 100;
        mem_lat_max = 0;
        force_rsp   = 1'b0;
        cyc         = 0;
        m_fetch_pc  = RESET_PC;
        m_drop      = 0;
        m_err       = 1'b0;
        @(posedge clk);
        #1;

        // Start-up with a zero-wait memory: first instruction two cycles
        // after reset release, then a gap-free PC sequence.
        $display("[TB] scenario: reset release");
        applyReset();
        acc.delete();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1_c0_ifv", 64'(last_ifv), 64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1_c1_ifv", 64'(last_ifv), 64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1_c2_ifv", 64'(last_ifv), 64'd1);
        checkOutput("t1_c2_pc", last_pc, 64'd0);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, '0, 1'b1);

        // IF/ID stall: buffer fills, requests stop, head is held.
        $display("[TB] scenario: stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            if (i >= 2) begin
                checkOutput("t2_hold_ifv", 64'(last_ifv), 64'd1);
                checkOutput("t2_hold_pc", last_pc, 64'(4 * acc.size()));
                checkOutput("t2_hold_req", 64'(last_req), 64'd0);
            end
        end
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, '0, 1'b1);
        checkAccSequence("t2_seq", 64'd0, 8);

        // Redirect with two fetches in flight: both responses are dropped.
        $display("[TB] scenario: redirect with fetches in flight");
        applyReset();
        rsp_pct = 0;
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 64'h100, 1'b1);
        rsp_pct = 100;
        acc.delete();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t3_drop_req0", 64'(last_req), 64'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t3_drop_req1", 64'(last_req), 64'd0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, '0, 1'b1);
        checkAccSequence("t3_seq", 64'h100, 2);

        // Redirect coinciding with the only in-flight response.
        $display("[TB] scenario: redirect with same-cycle response");
        applyReset();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t4_issue0", 64'(last_req), 64'd1);
        applyStimulus(1'b1, 64'h200, 1'b1);
        acc.delete();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t4_req_next", 64'(last_req), 64'd1);
        checkOutput("t4_addr_next", last_addr, 64'h200);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, '0, 1'b1);
        checkAccSequence("t4_seq", 64'h200, 2);

        // Spurious response with nothing outstanding; sticky until reset.
        $display("[TB] scenario: spurious response");
        ready_pct = 0;
        applyReset();
        force_rsp = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        force_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("t5_err_sticky", 64'(last_err), 64'd1);
            checkOutput("t5_ifv", 64'(last_ifv), 64'd0);
        end
        ready_pct = 100;
        applyReset();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t5_err_cleared", 64'(last_err), 64'd0);

        // PC wrap at the top of the address space.
        $display("[TB] scenario: pc wrap");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        acc.delete();
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, '0, 1'b1);
        checkAccSequence("t6_seq", 64'hFFFF_FFFF_FFFF_FFFC, 3);

        // Random traffic against the reference.
        $display("[TB] scenario: random");
        ready_pct   = 70;
        rsp_pct     = 70;
        mem_lat_max = 3;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            rpc = {$urandom, $urandom};
            if ($urandom_range(9) < 3)
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(3));
            rpc[1:0] = 2'b00;
            applyStimulus($urandom_range(99) < 4, rpc, $urandom_range(99) < 75);
            if (i == 200)
                applyReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
